// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// icache_pkg : shared encodings for the set-associative instruction cache
// Revision   : 1.0
// ============================================================================
package icache_pkg;

    localparam logic [2:0] RD_TYPE_WORD   = 3'b010;
    localparam logic [2:0] RD_TYPE_LINE   = 3'b100;

    localparam logic [1:0] CACOP_IDX_INV0 = 2'd0;
    localparam logic [1:0] CACOP_IDX_INV1 = 2'd1;
    localparam logic [1:0] CACOP_HIT_INV  = 2'd2;
    localparam logic [1:0] CACOP_NOP      = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_REQUEST = 3'd2,
        ST_RECEIVE = 3'd3,
        ST_CACOP   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/icache_way.sv
`default_nettype none
// ============================================================================
// icache_way : one way of tag/valid/data storage with combinational read
// Revision   : 1.0
// ============================================================================
module icache_way #(
    parameter int IDX_W  = 8,
    parameter int TAG_W  = 20,
    parameter int LINE_W = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic              i_we,
    input  logic [LINE_W-1:0] i_line,
    input  logic              i_clr,
    output logic              o_valid,
    output logic              o_hit,
    output logic [LINE_W-1:0] o_line
);

    localparam int SETS = 1 << IDX_W;

    logic [SETS-1:0]   r_valid;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [LINE_W-1:0] r_data [SETS];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else begin
            if (i_clr) r_valid[i_idx] <= 1'b0;
            if (i_we)  r_valid[i_idx] <= 1'b1;
        end
    end

    // Contents are only meaningful under a set valid bit, so they carry no reset.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_tag[i_idx]  <= i_tag;
            r_data[i_idx] <= i_line;
        end
    end

    assign o_valid = r_valid[i_idx];
    assign o_hit   = r_valid[i_idx] && (r_tag[i_idx] == i_tag);
    assign o_line  = r_data[i_idx];

endmodule
`default_nettype wire

// File: rtl/icache_sa.sv
`default_nettype none
// ============================================================================
// icache_sa : N-way set-associative ifetch cache, uncached word path, CACOP
// Revision  : 1.0
// ============================================================================
module icache_sa #(
    parameter int WAYS       = 2,
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [31:0]             araddr,
    input  logic                    uncached,
    output logic                    rvalid,
    output logic [32*LINE_WORDS-1:0] rdata,
    input  logic                    cacop_en,
    input  logic [1:0]              cacop_code,
    input  logic [31:0]             cacop_addr,
    output logic                    cacop_ok,
    output logic                    rd_req,
    output logic [2:0]              rd_type,
    output logic [31:0]             rd_addr,
    input  logic                    rd_rdy,
    input  logic                    ret_valid,
    input  logic                    ret_last,
    input  logic [31:0]             ret_data
);
    import icache_pkg::*;

    localparam int OFS_W  = $clog2(LINE_WORDS * 4);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - IDX_W - OFS_W;
    localparam int CNT_W  = OFS_W - 2;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LINE_W = 32 * LINE_WORDS;

    state_t            r_state;
    logic [31:0]       r_addr;
    logic              r_uncached;
    logic [CNT_W-1:0]  r_cnt;
    logic [LINE_W-1:0] r_line;
    logic [WAY_W-1:0]  r_rr [SETS];

    logic [31:0]       w_sel_addr;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [WAYS-1:0]   w_hit, w_valid, w_we, w_clr;
    logic [LINE_W-1:0] w_way_line [WAYS];
    logic [LINE_W-1:0] w_hit_line, w_fill_line;
    logic [WAY_W-1:0]  w_victim, w_rr_next;
    logic              w_lookup_hit, w_done, w_unused;

    // The single array port serves the cache op address while in CACOP.
    assign w_sel_addr = (r_state == ST_CACOP) ? cacop_addr : r_addr;
    assign w_idx      = w_sel_addr[OFS_W+IDX_W-1:OFS_W];
    assign w_tag      = w_sel_addr[31:32-TAG_W];
    assign w_unused   = ^{w_sel_addr[OFS_W-1:0], r_addr[1:0], cacop_addr};

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            icache_way #(.IDX_W(IDX_W), .TAG_W(TAG_W), .LINE_W(LINE_W)) u_way (
                .clock   (clock),
                .reset   (reset),
                .i_idx   (w_idx),
                .i_tag   (w_tag),
                .i_we    (w_we[gi]),
                .i_line  (w_fill_line),
                .i_clr   (w_clr[gi]),
                .o_valid (w_valid[gi]),
                .o_hit   (w_hit[gi]),
                .o_line  (w_way_line[gi])
            );
        end
    endgenerate

    always_comb begin
        w_hit_line = '0;
        for (int w = 0; w < WAYS; w++)
            if (w_hit[w]) w_hit_line = w_hit_line | w_way_line[w];
    end

    // Beat k lands in word LINE_WORDS-1-k, so the first beat is the top word.
    always_comb begin
        w_fill_line = r_line;
        for (int k = 0; k < LINE_WORDS; k++)
            if (r_cnt == CNT_W'(k)) w_fill_line[32*(LINE_WORDS-k)-1 -: 32] = ret_data;
    end

    always_comb begin
        w_victim = r_rr[w_idx];
        for (int w = WAYS - 1; w >= 0; w--)
            if (!w_valid[w]) w_victim = WAY_W'(w);
    end

    assign w_rr_next    = (int'(r_rr[w_idx]) == WAYS - 1) ? '0 : r_rr[w_idx] + WAY_W'(1);
    assign w_lookup_hit = (r_state == ST_LOOKUP) && (|w_hit);
    assign w_done       = (r_state == ST_RECEIVE) && ret_valid &&
                          (ret_last || (r_cnt == CNT_W'(LINE_WORDS - 1)));

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            w_we[w]  = w_done && !r_uncached && (w_victim == WAY_W'(w));
            w_clr[w] = 1'b0;
            if (r_state == ST_CACOP) begin
                case (cacop_code)
                    CACOP_IDX_INV0, CACOP_IDX_INV1:
                        w_clr[w] = (WAYS == 1) || (cacop_addr[WAY_W-1:0] == WAY_W'(w));
                    CACOP_HIT_INV:
                        w_clr[w] = w_hit[w];
                    default:
                        w_clr[w] = 1'b0;
                endcase
            end
        end
    end

    assign arready  = (r_state == ST_IDLE) && !cacop_en && arvalid;
    assign cacop_ok = (r_state == ST_CACOP);
    assign rvalid   = w_lookup_hit || w_done;
    assign rdata    = w_lookup_hit ? w_hit_line :
                      !w_done      ? '0 :
                      r_uncached   ? LINE_W'(ret_data) : w_fill_line;
    assign rd_req   = (r_state == ST_REQUEST);
    assign rd_type  = !rd_req ? 3'b000 : (r_uncached ? RD_TYPE_WORD : RD_TYPE_LINE);
    assign rd_addr  = !rd_req    ? 32'd0 :
                      r_uncached ? {r_addr[31:2], 2'b00} :
                                   {r_addr[31:OFS_W], {OFS_W{1'b0}}};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_uncached <= 1'b0;
            r_cnt      <= '0;
            r_line     <= '0;
            for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cacop_en) begin
                        r_state <= ST_CACOP;
                    end else if (arvalid) begin
                        r_addr     <= araddr;
                        r_uncached <= uncached;
                        r_state    <= uncached ? ST_REQUEST : ST_LOOKUP;
                    end
                end
                ST_LOOKUP:  r_state <= (|w_hit) ? ST_IDLE : ST_REQUEST;
                ST_REQUEST: begin
                    if (rd_rdy) begin
                        r_state <= ST_RECEIVE;
                        r_cnt   <= '0;
                    end
                end
                ST_RECEIVE: begin
                    if (ret_valid) begin
                        r_line <= w_fill_line;
                        r_cnt  <= r_cnt + CNT_W'(1);
                        if (w_done) begin
                            r_state <= ST_IDLE;
                            if (!r_uncached && (&w_valid)) r_rr[w_idx] <= w_rr_next;
                        end
                    end
                end
                ST_CACOP:   r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_sa.sv
`default_nettype none
// ============================================================================
// tb_icache_sa : directed self-checking bench for icache_sa (2 ways, 4-word lines)
// Revision     : 1.0
// ============================================================================
module tb_icache_sa;

    logic         clock, reset;
    logic         arvalid, arready, uncached, rvalid;
    logic [31:0]  araddr;
    logic [127:0] rdata;
    logic         cacop_en, cacop_ok;
    logic [1:0]   cacop_code;
    logic [31:0]  cacop_addr;
    logic         rd_req, rd_rdy, ret_valid, ret_last;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr, ret_data;

    int vectors;
    int miscompares;

    localparam logic [127:0] L1 = {32'h11, 32'h22, 32'h33, 32'h44};
    localparam logic [127:0] L2 = {32'hA1, 32'hA2, 32'hA3, 32'hA4};
    localparam logic [127:0] L3 = {32'hB1, 32'hB2, 32'hB3, 32'hB4};
    localparam logic [127:0] L4 = {32'hC1, 32'hC2, 32'hC3, 32'hC4};
    localparam logic [127:0] LU = {32'hDEADBEEF, 96'd0};

    icache_sa #(.WAYS(2), .SETS(256), .LINE_WORDS(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .arvalid    (arvalid),
        .arready    (arready),
        .araddr     (araddr),
        .uncached   (uncached),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .cacop_en   (cacop_en),
        .cacop_code (cacop_code),
        .cacop_addr (cacop_addr),
        .cacop_ok   (cacop_ok),
        .rd_req     (rd_req),
        .rd_type    (rd_type),
        .rd_addr    (rd_addr),
        .rd_rdy     (rd_rdy),
        .ret_valid  (ret_valid),
        .ret_last   (ret_last),
        .ret_data   (ret_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    always @(negedge clock) begin
        if (!reset) begin
            assert ($countones(dut.w_hit) <= 1) else begin
                miscompares++;
                $error("FAIL multi_hit: observed %b expected at most one hit", dut.w_hit);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic unc);
        arvalid = 1'b1; araddr = addr; uncached = unc;
        #1 chk("arready", 128'(arready), 128'(1));
        tick();
        arvalid = 1'b0; uncached = 1'b0;
        #1;
    endtask

    task automatic fetch_hit(input logic [31:0] addr, input logic [127:0] line);
        do_fetch(addr, 1'b0);
        chk("hit_rvalid", 128'(rvalid), 128'(1));
        chk("hit_rdata", rdata, line);
        chk("hit_no_req", 128'(rd_req), 128'(0));
        tick();
        chk("hit_done", 128'(rvalid), 128'(0));
    endtask

    task automatic fetch_miss(input logic [31:0] addr, input logic unc, input logic [31:0] exp_raddr,
                              input logic [127:0] line, input logic use_last);
        int n;
        logic [127:0] exp_line;
        n = unc ? 1 : 4;
        exp_line = unc ? {96'd0, line[127:96]} : line;
        do_fetch(addr, unc);
        if (!unc) begin
            chk("lookup_miss", 128'(rvalid), 128'(0));
            tick();
        end
        ret_valid = 1'b1; ret_data = 32'hBAD0BAD0; ret_last = 1'b1;
        #1;
        chk("req", 128'(rd_req), 128'(1));
        chk("req_addr", 128'(rd_addr), 128'(exp_raddr));
        chk("req_type", 128'(rd_type), unc ? 128'(3'b010) : 128'(3'b100));
        chk("stray_beat", 128'(rvalid), 128'(0));
        tick();
        ret_valid = 1'b0; ret_last = 1'b0; rd_rdy = 1'b1;
        #1 chk("req_held", 128'(rd_req), 128'(1));
        tick();
        rd_rdy = 1'b0;
        for (int k = 0; k < n; k++) begin
            ret_valid = 1'b1;
            ret_data  = line[127-32*k -: 32];
            ret_last  = use_last && (k == n - 1);
            #1;
            if (k == n - 1) begin
                chk("fill_rvalid", 128'(rvalid), 128'(1));
                chk("fill_rdata", rdata, exp_line);
            end else begin
                chk("beat_rvalid", 128'(rvalid), 128'(0));
            end
            tick();
        end
        ret_valid = 1'b0; ret_last = 1'b0;
        #1 chk("fill_idle", 128'(rvalid), 128'(0));
    endtask

    task automatic do_cacop(input logic [1:0] code, input logic [31:0] addr);
        cacop_en = 1'b1; cacop_code = code; cacop_addr = addr;
        #1 chk("cacop_wait", 128'(cacop_ok), 128'(0));
        tick();
        chk("cacop_ok", 128'(cacop_ok), 128'(1));
        cacop_en = 1'b0;
        tick();
        chk("cacop_pulse", 128'(cacop_ok), 128'(0));
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b1; arvalid = 1'b0; araddr = '0; uncached = 1'b0;
        cacop_en = 1'b0; cacop_code = '0; cacop_addr = '0;
        rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0;
        tick(); tick();
        chk("rst_arready", 128'(arready), 128'(0));
        chk("rst_rvalid", 128'(rvalid), 128'(0));
        chk("rst_rdata", rdata, 128'(0));
        chk("rst_cacop_ok", 128'(cacop_ok), 128'(0));
        chk("rst_rd_req", 128'(rd_req), 128'(0));
        reset = 1'b0;
        tick();

        // Cold miss then hit; conflict fills on idx 4 with round-robin eviction
        fetch_miss(32'h1C000040, 1'b0, 32'h1C000040, L1, 1'b1);
        fetch_hit (32'h1C000048, L1);
        fetch_miss(32'h2C000040, 1'b0, 32'h2C000040, L2, 1'b1);
        fetch_miss(32'h3C000044, 1'b0, 32'h3C000040, L3, 1'b0);
        fetch_hit (32'h2C000040, L2);
        fetch_miss(32'h1C000040, 1'b0, 32'h1C000040, L1, 1'b1);
        fetch_hit (32'h3C000044, L3);
        fetch_miss(32'h2C00004C, 1'b0, 32'h2C000040, L2, 1'b1);

        // Hit invalidate clears only the matching way
        do_cacop(2'd2, 32'h2C000040);
        fetch_miss(32'h2C000040, 1'b0, 32'h2C000040, L2, 1'b1);
        fetch_hit (32'h1C000040, L1);

        // Index invalidate of way 1
        do_cacop(2'd1, 32'h1C000041);
        fetch_hit (32'h2C000040, L2);
        fetch_miss(32'h1C000040, 1'b0, 32'h1C000040, L1, 1'b1);

        // Uncached word, then the same line cached still misses
        fetch_miss(32'hBFC00004, 1'b1, 32'hBFC00004, LU, 1'b1);
        fetch_miss(32'hBFC00000, 1'b0, 32'hBFC00000, L4, 1'b1);
        fetch_hit (32'hBFC0000C, L4);

        // Fetch and cacop together: cacop first, fetch the cycle after cacop_ok
        arvalid = 1'b1; araddr = 32'h2C000048; cacop_en = 1'b1; cacop_code = 2'd3;
        #1 chk("both_arready", 128'(arready), 128'(0));
        tick();
        chk("both_cacop_ok", 128'(cacop_ok), 128'(1));
        chk("both_arready_cacop", 128'(arready), 128'(0));
        cacop_en = 1'b0;
        tick();
        chk("both_accept", 128'(arready), 128'(1));
        tick();
        arvalid = 1'b0;
        #1;
        chk("both_hit_rvalid", 128'(rvalid), 128'(1));
        chk("both_hit_rdata", rdata, L2);
        tick();

        // Reset in the middle of a line fill
        do_fetch(32'h4C000040, 1'b0);
        chk("rr_lookup", 128'(rvalid), 128'(0));
        tick();
        rd_rdy = 1'b1;
        #1 chk("rr_req", 128'(rd_req), 128'(1));
        tick();
        rd_rdy = 1'b0;
        ret_valid = 1'b1; ret_data = 32'h1; tick();
        ret_data = 32'h2; tick();
        ret_data = 32'h3; reset = 1'b1;
        #1;
        chk("mid_rst_rvalid", 128'(rvalid), 128'(0));
        chk("mid_rst_rdata", rdata, 128'(0));
        chk("mid_rst_rd_req", 128'(rd_req), 128'(0));
        tick();
        reset = 1'b0;
        ret_data = 32'h4; ret_last = 1'b1;
        #1 chk("late_beat", 128'(rvalid), 128'(0));
        tick();
        ret_valid = 1'b0; ret_last = 1'b0;
        #1 chk("late_beat_done", 128'(rvalid), 128'(0));
        fetch_miss(32'h2C000040, 1'b0, 32'h2C000040, L2, 1'b1);
        fetch_miss(32'hBFC00000, 1'b0, 32'hBFC00000, L4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
